// File: rtl/sync_fifo_pkg.sv
// Shared types and constants for the parametrised synchronous FIFO.
//   fifo_status_t : packed bundle of the FIFO's status flags
//   addr_width()  : pointer width for a given depth
//   count_width() : occupancy counter width (one bit wider than a pointer)
package sync_fifo_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 32;

  typedef struct packed {
    logic full;
    logic almost_full;
    logic empty;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  function automatic int addr_width(input int depth);
    return $clog2(depth);
  endfunction

  // The count must represent DEPTH itself, hence the extra bit.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array for sync_fifo_param: DEPTH x WIDTH, one write port, one read port.
// Contents are never reset.
// Build option FIFO_FWFT_EN:
//   defined   - read port is combinational (rdata = mem[raddr]); re and rst_n unused
//   undefined - read port is registered: rdata <= mem[raddr] when re, cleared by reset
// Ports:
//   clk, rst_n     clock / asynchronous active-low reset (registered read data only)
//   we, waddr, wdata   write port
//   re, raddr, rdata   read port
module sync_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_reg[waddr] <= wdata;
    end
  end

`ifdef FIFO_FWFT_EN
  logic unused_inputs;
  assign unused_inputs = re ^ rst_n;
  assign rdata         = mem_reg[raddr];
`else
  logic [WIDTH-1:0] rdata_reg;

  // Non-blocking semantics give read-before-write when raddr == waddr,
  // which the full-FIFO simultaneous read/write case relies on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_reg <= '0;
    end else if (re) begin
      rdata_reg <= mem_reg[raddr];
    end
  end

  assign rdata = rdata_reg;
`endif

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with fill count, read-valid strobe,
// sticky overflow/underflow flags and synchronous flush.
// Build option FIFO_FWFT_EN: first-word-fall-through output (dout shows the
// head whenever not empty, rd_valid = !empty); otherwise 1-cycle registered read.
// Ports:
//   clk, rst_n        clock / asynchronous active-low reset
//   flush             synchronous clear of pointers, count and rd_valid
//   wr_en, din        write request and data
//   rd_en, dout       read request and data; rd_valid marks fresh dout
//   full, almost_full, empty, almost_empty, count   occupancy status
//   overflow, underflow, err_clr                     sticky errors and their clear
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  localparam int AW       = addr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             almost_full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             rd_valid,
  output logic             empty,
  output logic             almost_empty,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow,
  input  logic             err_clr
);

  localparam int          CW       = count_width(DEPTH);
  localparam logic [AW:0] FULL_LVL = CW'(DEPTH);
  localparam logic [AW:0] AF_LVL   = CW'(AF_THRESH);
  localparam logic [AW:0] AE_LVL   = CW'(AE_THRESH);

  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW:0]   count_reg, count_next;
  logic          overflow_reg, overflow_next;
  logic          underflow_reg, underflow_next;
  logic          wr_acc, rd_acc, ovf_set, udf_set;
  logic [WIDTH-1:0] mem_rdata;
  fifo_status_t  status;

  // Flags decode straight from the registered count.
  assign status.full         = (count_reg == FULL_LVL);
  assign status.almost_full  = (count_reg >= AF_LVL);
  assign status.empty        = (count_reg == '0);
  assign status.almost_empty = (count_reg <= AE_LVL);
  assign status.overflow     = overflow_reg;
  assign status.underflow    = underflow_reg;

  // A read frees a slot in the same cycle, so a full FIFO still accepts a
  // write alongside an accepted read. Flush masks both requests.
  assign rd_acc  = rd_en && !status.empty && !flush;
  assign wr_acc  = wr_en && (!status.full || rd_acc) && !flush;
  assign ovf_set = wr_en && status.full && !rd_acc && !flush;
  assign udf_set = rd_en && status.empty && !flush;

  always_comb begin
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    count_next     = count_reg;
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;

    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (wr_acc) wr_ptr_next = wr_ptr_reg + AW'(1);
      if (rd_acc) rd_ptr_next = rd_ptr_reg + AW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count_next = count_reg + CW'(1);
        2'b01:   count_next = count_reg - CW'(1);
        default: count_next = count_reg;
      endcase
    end

    // Clearing wins over a same-cycle error; that error is not recorded.
    if (err_clr) begin
      overflow_next  = 1'b0;
      underflow_next = 1'b0;
    end else begin
      if (ovf_set) overflow_next  = 1'b1;
      if (udf_set) underflow_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  sync_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_acc),
    .waddr (wr_ptr_reg),
    .wdata (din),
    .re    (rd_acc),
    .raddr (rd_ptr_reg),
    .rdata (mem_rdata)
  );

`ifdef FIFO_FWFT_EN
  assign dout     = status.empty ? '0 : mem_rdata;
  assign rd_valid = !status.empty;
`else
  logic rd_valid_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= rd_acc;
    end
  end

  assign dout     = mem_rdata;
  assign rd_valid = rd_valid_reg;
`endif

  assign full         = status.full;
  assign almost_full  = status.almost_full;
  assign empty        = status.empty;
  assign almost_empty = status.almost_empty;
  assign overflow     = status.overflow;
  assign underflow    = status.underflow;
  assign count        = count_reg;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param (default build, registered read).
// A queue-based reference model predicts every output after each clock.
module tb_sync_fifo_param;

  localparam int WIDTH = 8;
  localparam int DEPTH = 32;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             wr_en = 1'b0;
  logic             rd_en = 1'b0;
  logic             err_clr = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic [WIDTH-1:0] dout;
  logic             full, almost_full, empty, almost_empty;
  logic             rd_valid, overflow, underflow;
  logic [5:0]       count;

  int checks = 0;
  int failures = 0;
  int txn = 0;

  // Reference model state
  logic [WIDTH-1:0] q[$];
  logic             m_ovf = 1'b0;
  logic             m_udf = 1'b0;
  logic             m_rdv = 1'b0;
  logic [WIDTH-1:0] m_dout = '0;

  always #5 clk = ~clk;

  sync_fifo_param #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .AF_THRESH (AF),
    .AE_THRESH (AE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .wr_en        (wr_en),
    .din          (din),
    .full         (full),
    .almost_full  (almost_full),
    .rd_en        (rd_en),
    .dout         (dout),
    .rd_valid     (rd_valid),
    .empty        (empty),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .err_clr      (err_clr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    m_rdv  = 1'b0;
    m_dout = '0;
  endtask

  // Applies one clock's worth of requests to the model, judged on pre-edge state.
  task automatic model_apply(input bit w, input logic [WIDTH-1:0] d, input bit r,
                             input bit f, input bit ec);
    bit was_full, was_empty, rd_ok, wr_ok, ovf_ev, udf_ev;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    ovf_ev = 1'b0;
    udf_ev = 1'b0;
    if (f) begin
      q.delete();
      m_rdv = 1'b0;
    end else begin
      rd_ok = r && !was_empty;
      wr_ok = w && (!was_full || rd_ok);
      if (rd_ok) m_dout = q.pop_front();
      m_rdv = rd_ok;
      if (wr_ok) q.push_back(d);
      ovf_ev = w && was_full && !rd_ok;
      udf_ev = r && was_empty;
    end
    if (ec) begin
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (ovf_ev) m_ovf = 1'b1;
      if (udf_ev) m_udf = 1'b1;
    end
  endtask

  task automatic compare_all();
    check("count",        32'(count),   32'(q.size()));
    check("full",         32'(full),    32'(q.size() == DEPTH));
    check("almost_full",  32'(almost_full), 32'(q.size() >= AF));
    check("empty",        32'(empty),   32'(q.size() == 0));
    check("almost_empty", 32'(almost_empty), 32'(q.size() <= AE));
    check("overflow",     32'(overflow),  32'(m_ovf));
    check("underflow",    32'(underflow), 32'(m_udf));
    check("rd_valid",     32'(rd_valid),  32'(m_rdv));
    check("dout",         32'(dout),      32'(m_dout));
  endtask

  task automatic step(input bit w, input logic [WIDTH-1:0] d, input bit r,
                      input bit f = 1'b0, input bit ec = 1'b0);
    @(negedge clk);
    wr_en   = w;
    din     = d;
    rd_en   = r;
    flush   = f;
    err_clr = ec;
    model_apply(w, d, r, f, ec);
    @(posedge clk);
    #1;
    compare_all();
    txn++;
    $display("txn %0d wr=%0b din=%02h rd=%0b fl=%0b ec=%0b -> count=%0d dout=%02h rv=%0b ovf=%0b udf=%0b",
             txn, w, d, r, f, ec, count, dout, rd_valid, overflow, underflow);
  endtask

  // Asserts rst_n between clock edges and checks outputs before any edge arrives.
  task automatic async_reset();
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; err_clr = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    $display("txn reset-asserted count=%0d empty=%0b", count, empty);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Power-on reset
    @(posedge clk);
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Single write/read round trip
    step(1'b1, 8'h7C, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    check("tp_rt_dout", 32'(dout), 32'h7C);
    check("tp_rt_valid", 32'(rd_valid), 32'd1);
    step(1'b0, 8'h00, 1'b0);

    // Fill to full, then overflow, then oldest comes out first
    for (int i = 0; i < DEPTH; i++) step(1'b1, WIDTH'(i), 1'b0);
    step(1'b1, 8'hEE, 1'b0);
    check("tp_ovf", 32'(overflow), 32'd1);
    step(1'b0, 8'h00, 1'b1);
    check("tp_ovf_first", 32'(dout), 32'h00);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Wrap-around ordering
    for (int i = 0; i < DEPTH; i++) step(1'b1, WIDTH'(8'h40 + i), 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h77, 1'b0);
    for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 8'h00, 1'b1);
    check("tp_wrap_last", 32'(dout), 32'h77);

    // Full: simultaneous write/read keeps count, returns oldest
    for (int i = 0; i < DEPTH; i++) step(1'b1, WIDTH'(8'h80 + i), 1'b0);
    step(1'b1, 8'hAA, 1'b1);
    check("tp_full_rw_dout", 32'(dout), 32'h80);
    check("tp_full_rw_count", 32'(count), 32'd32);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Empty: simultaneous write/read -> underflow, count 1
    step(1'b1, 8'h55, 1'b1);
    check("tp_empty_rw_count", 32'(count), 32'd1);
    step(1'b0, 8'h00, 1'b1);
    check("tp_empty_rw_dout", 32'(dout), 32'h55);

    // Underflow, clear, and clear-wins-over-new-error
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    check("tp_clr_prio", 32'(underflow), 32'd0);

    // Flush after 5 writes
    for (int i = 0; i < 5; i++) step(1'b1, WIDTH'(8'hC0 + i), 1'b0);
    step(1'b1, 8'hFF, 1'b1, 1'b1, 1'b0);

    // Reset mid-stream, then fresh data from address 0
    step(1'b1, 8'h12, 1'b0);
    step(1'b1, 8'h13, 1'b0);
    async_reset();
    step(1'b1, 8'h34, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    check("tp_post_rst_dout", 32'(dout), 32'h34);

    // Randomized phases alternating write-heavy and read-heavy traffic
    for (int p = 0; p < 6; p++) begin
      for (int n = 0; n < 100; n++) begin
        int wp;
        bit w, r, f, ec;
        wp = (p % 2 == 0) ? 85 : 15;
        w  = ($urandom_range(99) < wp);
        r  = ($urandom_range(99) < (100 - wp));
        f  = ($urandom_range(63) == 0);
        ec = ($urandom_range(15) == 0);
        step(w, WIDTH'($urandom), r, f, ec);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised synchronous single-clock FIFO and the successor to the fixed 32x8 FIFO. Width, depth and almost-full/almost-empty thresholds are generic. Adds fill count, a read-valid strobe, sticky overflow/underflow error flags, and a synchronous flush. Used as the standard elastic buffer between same-clock producer and consumer blocks.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 32, number of entries; power of two, >=4
AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH
AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH
(localparam) AW = $clog2(DEPTH); count width is AW+1

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous assert, active-low
flush  in  1  synchronous clear of contents and pointers
wr_en  in  1  write request
din  in  WIDTH  write data
full  out  1  count == DEPTH
almost_full  out  1  count >= AF_THRESH
rd_en  in  1  read request
dout  out  WIDTH  read data
rd_valid  out  1  dout updated by an accepted read
empty  out  1  count == 0
almost_empty  out  1  count <= AE_THRESH
count  out  AW+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: a write was dropped
underflow  out  1  sticky: a read was rejected
err_clr  in  1  synchronous clear of overflow/underflow

Behaviour:
- Reset (rst_n=0, asynchronous): wr_ptr=rd_ptr=0, count=0, dout=0, rd_valid=0, overflow=underflow=0, empty=1, almost_empty=1, full=0, almost_full=0. Memory contents are not reset.
- Pointers are AW bits wide and wrap modulo DEPTH naturally. count is held as an explicit register; flags are decoded from registered count, so they are valid in the cycle after the edge.
- Write accept: wr_en && (!full || rd_accept). Accepted data goes to mem[wr_ptr], and wr_ptr increments.
- Read accept: rd_en && !empty. dout <= mem[rd_ptr] and rd_ptr increments. Latency is 1 cycle, with rd_valid=1 in the cycle after acceptance. Otherwise rd_valid=0 and dout holds its last value.
- count changes by +1 on write only, -1 on read only, and is unchanged when both or neither are accepted.
- Simultaneous rd/wr:
  - Full: both accepted; count stays DEPTH and full stays 1.
  - Empty: write accepted, read rejected (underflow set), count becomes 1.
  - Otherwise: both accepted.
- Overflow: wr_en && full && !rd_accept. Data is dropped, state is unchanged, overflow=1 until err_clr or reset.
- Underflow: rd_en && empty. dout is held, rd_valid=0, underflow=1 until err_clr or reset.
- err_clr has priority over a same-cycle error set. The flag clears, and the new error is not recorded.
- flush (synchronous): pointers and count go to 0 and rd_valid=0. wr_en/rd_en are ignored that cycle. dout and error flags are kept.
- Reset mid-burst aborts immediately. The first write after rst_n deasserts lands at address 0.

Optional Feature:
FIFO_FWFT_EN
- Defined: first-word-fall-through mode. dout = mem[rd_ptr] combinationally whenever !empty, and rd_valid = !empty. rd_en pops the head with zero latency. Underflow, overflow and flag rules are unchanged.
- Undefined: registered 1-cycle read as described in Behaviour.

Decomposition:
- Package sync_fifo_pkg:
  - fifo_status_t struct {full, almost_full, empty, almost_empty, overflow, underflow}
  - function for pointer/count width
  - default WIDTH/DEPTH constants
- One sub-module, sync_fifo_mem: DEPTH x WIDTH register array with one write port and one read port. The read port is registered or combinational depending on FIFO_FWFT_EN.
- Pointer, count and flag control live in the top module.

Test Plan:
- Reset, write 0x7C, read → rd_valid=1 one cycle after the read and dout=0x7C; then empty=1 and count=0.
- 32 writes of 0..31 → full=1, count=32, almost_full from count 30 onward; a 33rd write drops, overflow=1, and the subsequent read returns 0x00.
- Fill 32, read 2, write 0x77, read 31 → the last read returns 0x77, showing wrap-around and order preserved.
- When full, simultaneous wr 0xAA/rd → count stays 32 and dout returns the oldest entry. When empty, simultaneous wr 0x55/rd → underflow=1, count=1, and the next read returns 0x55.
- Read when empty → rd_valid=0, dout unchanged, underflow=1. err_clr → underflow=0. err_clr plus a read when empty in the same cycle → underflow stays 0.
- Write 5 words, flush → count=0 and empty=1. Write 0x12 with rst_n pulsed low mid-stream → all outputs at reset values immediately, and the next write/read returns the new data.
